// File: rtl/aibio_hvmadc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aibio_hvmadc_pkg
//  Description : Shared types and constants for the HVM ADC channel sequencer:
//                FSM state encoding, channel count, ADC code width and the
//                channel search helper used by the sweep logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package aibio_hvmadc_pkg;

    localparam int NUM_CH = 8;   // ADC mux inputs
    localparam int CH_W   = 3;   // index width for NUM_CH channels
    localparam int CODE_W = 10;  // ADC conversion code width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SETTLE = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_STORE  = 3'd5
    } seq_state_t;

    // Lowest set bit of mask at index >= from. The MSB of the result flags
    // whether any channel was found; 'from' is one bit wider than an index so
    // that NUM_CH can express "past the last channel".
    function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] mask,
                                              input logic [CH_W:0]     from);
        logic [CH_W:0] res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && ((CH_W + 1)'(i) >= from)) begin
                res = {1'b1, CH_W'(i)};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aibio_hvmadc_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : aibio_hvmadc_seq_if
//  Description : Sequencer <-> HVM ADC signal bundle.
//                master : sequencer side (drives enable/start/mux select)
//                slave  : ADC side (drives done flag and conversion code)
//  Signals     : adc_en, adc_start, adc_anamux_sel[2:0], adcdone, adcout[9:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface aibio_hvmadc_seq_if;
    import aibio_hvmadc_pkg::*;

    logic              adc_en;
    logic              adc_start;
    logic [CH_W-1:0]   adc_anamux_sel;
    logic              adcdone;
    logic [CODE_W-1:0] adcout;

    modport master (
        output adc_en,
        output adc_start,
        output adc_anamux_sel,
        input  adcdone,
        input  adcout
    );

    modport slave (
        input  adc_en,
        input  adc_start,
        input  adc_anamux_sel,
        output adcdone,
        output adcout
    );

endinterface
`default_nettype wire

// File: rtl/aibio_hvmadc_done_sync.sv
`default_nettype none
// ============================================================================
//  Module      : aibio_hvmadc_done_sync
//  Description : Two-flop synchronizer for the asynchronous ADC done flag plus
//                a rising-edge detector on the synchronized level.
//  Ports       : adcclk    - clock
//                reset_n   - asynchronous active-low reset
//                adcdone   - raw done flag from the ADC
//                done_rise - one-cycle pulse on a synchronized rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module aibio_hvmadc_done_sync (
    input  wire logic adcclk,
    input  wire logic reset_n,
    input  wire logic adcdone,
    output logic      done_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge adcclk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= adcdone;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign done_rise = r_sync & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/aibio_hvmadc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aibio_hvmadc_seq
//  Description : HVM ADC channel sequencer. Sweeps the enabled mux inputs in
//                ascending order, settles, pulses adc_start, waits for the
//                synchronized done edge and stores the code per channel.
//  Ports       : adcclk, reset_n      - clock, async active-low reset
//                seq_en, seq_cont     - sweep request, continuous mode
//                ch_en, settle_cyc    - channel mask, mux settle cycles
//                rd_ch/rd_data/rd_valid - combinational result read port
//                adc (if.master)      - adc_en/adc_start/mux sel, done/code
//                seq_busy, seq_done   - status, end-of-sweep pulse
//                err_timeout          - sticky per-channel timeout flags
//  Config      : AIBIO_HVMADC_SEQ_TIMEOUT_EN - abort a conversion after
//                TIMEOUT_CYC cycles in WAIT and flag err_timeout[ch].
//  Revision    : 1.0 - initial release
// ============================================================================
module aibio_hvmadc_seq
    import aibio_hvmadc_pkg::*;
#(
    parameter int SETTLE_W    = 4,
    parameter int START_CYC   = 4,
    parameter int TIMEOUT_CYC = 32768
) (
    input  wire logic                adcclk,
    input  wire logic                reset_n,
    input  wire logic                seq_en,
    input  wire logic                seq_cont,
    input  wire logic [NUM_CH-1:0]   ch_en,
    input  wire logic [SETTLE_W-1:0] settle_cyc,
    input  wire logic [CH_W-1:0]     rd_ch,
    aibio_hvmadc_seq_if.master       adc,
    output logic [CODE_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     seq_busy,
    output logic                     seq_done,
    output logic [NUM_CH-1:0]        err_timeout
);

    localparam logic [15:0] C_START_LAST = 16'(START_CYC - 1);
    localparam logic [15:0] C_CNT_MAX    = 16'(TIMEOUT_CYC - 1);

    seq_state_t          r_state, w_state_next;
    logic [CH_W-1:0]     r_ptr, w_ptr_next;
    logic [NUM_CH-1:0]   r_mask, w_mask_next;
    logic                r_relatch, w_relatch_next;
    logic [15:0]         r_cnt;
    logic [CODE_W-1:0]   r_result [NUM_CH];
    logic [NUM_CH-1:0]   r_valid;

    logic                w_done_rise;
    logic                w_clr_valid;
    logic                w_store;
    logic                w_finish;
    logic [CH_W:0]       w_sel;
    logic [CH_W:0]       w_hi;
`ifdef AIBIO_HVMADC_SEQ_TIMEOUT_EN
    logic                w_tmo;
    logic [NUM_CH-1:0]   r_err;
`endif

    aibio_hvmadc_done_sync u_done_sync (
        .adcclk    (adcclk),
        .reset_n   (reset_n),
        .adcdone   (adc.adcdone),
        .done_rise (w_done_rise)
    );

    always_ff @(posedge adcclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_mask    <= '0;
            r_relatch <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_mask    <= w_mask_next;
            r_relatch <= w_relatch_next;
            // Per-state cycle counter; saturating so an endless WAIT is benign.
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Wrap-around re-latch is deferred to SELECT (r_relatch) so the last
    // stored valid bit of a sweep is visible for a cycle before it clears.
    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_mask_next    = r_mask;
        w_relatch_next = r_relatch;
        w_clr_valid    = 1'b0;
        w_store        = 1'b0;
        w_finish       = 1'b0;
        seq_done       = 1'b0;
`ifdef AIBIO_HVMADC_SEQ_TIMEOUT_EN
        w_tmo          = 1'b0;
`endif
        w_sel = find_ch(r_relatch ? ch_en : r_mask,
                        r_relatch ? 4'd0 : {1'b0, r_ptr});
        w_hi  = find_ch(r_mask, {1'b0, r_ptr} + 4'd1);

        case (r_state)
            ST_IDLE: begin
                if (seq_en && (ch_en != '0)) begin
                    w_state_next = ST_SELECT;
                    w_mask_next  = ch_en;
                    w_ptr_next   = '0;
                    w_clr_valid  = 1'b1;
                end
            end
            ST_SELECT: begin
                w_relatch_next = 1'b0;
                if (r_relatch) begin
                    w_mask_next = ch_en;
                    w_clr_valid = 1'b1;
                end
                if (w_sel[CH_W]) begin
                    w_state_next = ST_SETTLE;
                    w_ptr_next   = w_sel[CH_W-1:0];
                end else begin
                    w_state_next = ST_IDLE;  // mask emptied at wrap
                end
            end
            ST_SETTLE: begin
                // Counter starts at 0 on entry, so settle_cyc=0 adds no
                // cycles beyond the single SETTLE visit.
                if (r_cnt >= 16'(settle_cyc)) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == C_START_LAST) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_done_rise) begin
                    w_state_next = ST_STORE;
                end
`ifdef AIBIO_HVMADC_SEQ_TIMEOUT_EN
                else if (r_cnt == C_CNT_MAX) begin
                    w_tmo    = 1'b1;
                    w_finish = 1'b1;
                end
`endif
            end
            ST_STORE: begin
                w_store  = 1'b1;
                w_finish = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Channel complete (stored or timed out): advance, wrap or stop.
        if (w_finish) begin
            if (!seq_en) begin
                w_state_next = ST_IDLE;
            end else if (w_hi[CH_W]) begin
                w_state_next = ST_SELECT;
                w_ptr_next   = r_ptr + 3'd1;
            end else begin
                seq_done = 1'b1;
                if (seq_cont) begin
                    w_state_next   = ST_SELECT;
                    w_ptr_next     = '0;
                    w_relatch_next = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge adcclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_result[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            if (w_clr_valid) begin
                r_valid <= '0;
            end else if (w_store) begin
                r_valid[r_ptr] <= 1'b1;
            end
            if (w_store) begin
                r_result[r_ptr] <= adc.adcout;
            end
        end
    end

`ifdef AIBIO_HVMADC_SEQ_TIMEOUT_EN
    always_ff @(posedge adcclk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= '0;
        end else if (w_tmo) begin
            r_err[r_ptr] <= 1'b1;
        end
    end
    assign err_timeout = r_err;
`else
    assign err_timeout = '0;
`endif

    assign seq_busy           = (r_state != ST_IDLE);
    assign adc.adc_en         = seq_busy;
    assign adc.adc_start      = (r_state == ST_START);
    assign adc.adc_anamux_sel = r_ptr;
    assign rd_data            = r_result[rd_ch];
    assign rd_valid           = r_valid[rd_ch];

endmodule
`default_nettype wire
